branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer_pkg.sv | 24 ++
 rtl/branch_sequencer_sat.sv | 24 ++
 rtl/branch_sequencer.sv | 147 ++++++++++++++
 tb/tb_branch_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared pipeline defines for the branch sequencer: default sizing, wait
// lengths and the sequencer state encoding.
package branch_sequencer_pkg;

  // Default statistics counter width.
  localparam int CNT_W_DEF    = 16;
  // Stall lengths loaded when the branch operand producer is in EX or MEM.
  localparam int EX_WAIT_DEF  = 2;
  localparam int MEM_WAIT_DEF = 1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STALL    = 2'd1,
    ST_EVAL     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Larger of two integers, used to size the wait counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_sequencer_sat.sv
// Saturating statistics counter: clears synchronously (clear wins over
// increment), holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  // Count up on inc until all-ones; clr zeroes the count on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer for the ID stage: stalls on operand hazards, resolves the
// branch, redirects the PC and squashes the wrong-path fetch, and keeps
// saturating statistics on branches, taken branches and stall cycles.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EX_WAIT  = EX_WAIT_DEF,
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_uncond,
  input  logic             haz_ex,
  input  logic             haz_mem,
  input  logic             cond_true,
  input  logic             clear_stats,
  output logic             stall,
  output logic             pc_sel,
  output logic             flush_if,
  output logic             br_done,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wide enough to hold the longer of the two wait lengths.
  localparam int WAIT_W = $clog2(max_int(EX_WAIT, MEM_WAIT) + 2);
  localparam logic [WAIT_W-1:0] EX_LOAD  = WAIT_W'(EX_WAIT);
  localparam logic [WAIT_W-1:0] MEM_LOAD = WAIT_W'(MEM_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  logic stall_c;
  logic pc_sel_c;
  logic flush_c;
  logic done_c;
  logic taken_c;
  logic resolve_c;

  // State and wait counter; reset returns to IDLE with no wait pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    stall_c   = 1'b0;
    pc_sel_c  = 1'b0;
    flush_c   = 1'b0;
    done_c    = 1'b0;
    taken_c   = 1'b0;
    resolve_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (br_valid) begin
          // Unconditional branches have no operand, so hazards are ignored.
          if (!br_uncond && (haz_ex || haz_mem)) begin
            stall_c   = 1'b1;
            // EX is the longer wait, so it wins when both hazards are flagged.
            wait_nxt  = haz_ex ? EX_LOAD : MEM_LOAD;
            state_nxt = ST_STALL;
          end else begin
            resolve_c = 1'b1;
          end
        end
      end

      ST_STALL: begin
        stall_c  = 1'b1;
        wait_nxt = (wait_cnt != '0) ? (wait_cnt - WAIT_W'(1)) : '0;
        // Last stall cycle when the count has run down to one.
        if (wait_cnt <= WAIT_W'(1)) begin
          state_nxt = ST_EVAL;
        end
      end

      ST_EVAL: begin
        // The producer has written back; the condition is now trustworthy
        // whatever the hazard inputs say.
        resolve_c = 1'b1;
      end

      ST_REDIRECT: begin
        // The instruction fetched behind a taken branch is wrong-path.
        flush_c   = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (resolve_c) begin
      done_c    = 1'b1;
      taken_c   = br_uncond | cond_true;
      pc_sel_c  = taken_c;
      flush_c   = taken_c;
      state_nxt = taken_c ? ST_REDIRECT : ST_IDLE;
    end
  end

  // Outputs are held low for the whole of reset, not just from the next edge.
  assign stall    = stall_c  & rst_n;
  assign pc_sel   = pc_sel_c & rst_n;
  assign flush_if = flush_c  & rst_n;
  assign br_done  = done_c   & rst_n;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_done),
    .clr   (clear_stats),
    .value (br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_done & pc_sel),
    .clr   (clear_stats),
    .value (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clr   (clear_stats),
    .value (stall_cnt)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: a directed preamble followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_branch_sequencer;

  localparam int CW   = 4;
  localparam int EXW  = 2;
  localparam int MEMW = 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          br_valid = 1'b0;
  logic          br_uncond = 1'b0;
  logic          haz_ex = 1'b0;
  logic          haz_mem = 1'b0;
  logic          cond_true = 1'b0;
  logic          clear_stats = 1'b0;
  logic          stall;
  logic          pc_sel;
  logic          flush_if;
  logic          br_done;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  branch_sequencer #(
    .CNT_W    (CW),
    .EX_WAIT  (EXW),
    .MEM_WAIT (MEMW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_valid    (br_valid),
    .br_uncond   (br_uncond),
    .haz_ex      (haz_ex),
    .haz_mem     (haz_mem),
    .cond_true   (cond_true),
    .clear_stats (clear_stats),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .flush_if    (flush_if),
    .br_done     (br_done),
    .br_cnt      (br_cnt),
    .taken_cnt   (taken_cnt),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic stall;
    logic pc_sel;
    logic flush_if;
    logic br_done;
    int   br;
    int   tk;
    int   st;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: cycles of stall still owed, whether a stalled branch
  // is waiting to resolve, whether a wrong-path squash is owed, and counts.
  int m_stall_left = 0;
  bit m_pending    = 1'b0;
  bit m_redirect   = 1'b0;
  int m_br = 0;
  int m_tk = 0;
  int m_st = 0;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected response for that cycle is queued.
  task automatic drive(input bit rv, input bit v, input bit u, input bit he,
                       input bit hm, input bit c, input bit clr);
    exp_t e;
    bit   res;
    bit   tk;
    @(posedge clk);
    #1;
    rst_n       = rv;
    br_valid    = v;
    br_uncond   = u;
    haz_ex      = he;
    haz_mem     = hm;
    cond_true   = c;
    clear_stats = clr;

    e.stall = 1'b0; e.pc_sel = 1'b0; e.flush_if = 1'b0; e.br_done = 1'b0;
    e.br = 0; e.tk = 0; e.st = 0;
    res = 1'b0;
    tk  = 1'b0;

    if (!rv) begin
      m_stall_left = 0;
      m_pending    = 1'b0;
      m_redirect   = 1'b0;
      m_br = 0; m_tk = 0; m_st = 0;
    end else begin
      e.br = m_br; e.tk = m_tk; e.st = m_st;
      if (m_redirect) begin
        e.flush_if = 1'b1;
        m_redirect = 1'b0;
      end else if (m_stall_left > 0) begin
        e.stall = 1'b1;
        m_stall_left--;
      end else if (m_pending) begin
        res = 1'b1;
        m_pending = 1'b0;
      end else if (v) begin
        if (!u && (he || hm)) begin
          e.stall      = 1'b1;
          m_stall_left = he ? EXW : MEMW;
          m_pending    = 1'b1;
        end else begin
          res = 1'b1;
        end
      end
      if (res) begin
        tk = u | c;
        e.br_done  = 1'b1;
        e.pc_sel   = tk;
        e.flush_if = tk;
        m_redirect = tk;
      end
      if (clr) begin
        m_br = 0; m_tk = 0; m_st = 0;
      end else begin
        if (res)     m_br = sat(m_br + 1);
        if (tk)      m_tk = sat(m_tk + 1);
        if (e.stall) m_st = sat(m_st + 1);
      end
    end
    sbq.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("stall",     32'(stall),     32'(e.stall));
      check("pc_sel",    32'(pc_sel),    32'(e.pc_sel));
      check("flush_if",  32'(flush_if),  32'(e.flush_if));
      check("br_done",   32'(br_done),   32'(e.br_done));
      check("br_cnt",    32'(br_cnt),    32'(e.br));
      check("taken_cnt", 32'(taken_cnt), 32'(e.tk));
      check("stall_cnt", 32'(stall_cnt), 32'(e.st));
    end
  end

  initial begin
    int drain;
    // Reset.
    drive(0, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // Taken branch with no hazard, then the redirect cycle and idle.
    drive(1, 1, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // EX hazard: branch held in ID through the stall.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Both hazards, not taken.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // MEM hazard alone.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Unconditional branch ignores a MEM hazard.
    drive(1, 1, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Reset during the second stall cycle, then a hazard-free branch.
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Saturation and clear: 17 taken branches, clear on the 17th.
    drive(1, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 0, 0, 0, 1, (i == 17));
      drive(1, 0, 0, 0, 0, 0, 0);
    end
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rv, v, u, he, hm, c, clr;
      rv  = ($urandom_range(0, 59) != 0);
      v   = $urandom_range(0, 1) == 1;
      u   = v && ($urandom_range(0, 4) == 0);
      he  = ($urandom_range(0, 2) == 0);
      hm  = ($urandom_range(0, 2) == 0);
      c   = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 39) == 0);
      drive(rv, v, u, he, hm, c, clr);
    end
    drain = 0;
    while (sbq.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
